// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_sequencer: keypad-to-result controller for the +/- calculator.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module calc_sequencer #(
  parameter int NDIG = 4,
  parameter int W    = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [1:0]   op_val,
  output logic [W-1:0] display_val,
  output logic         display_neg,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int          CW       = $clog2(NDIG + 1);
  localparam int unsigned MAX_VAL  = 10**NDIG - 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_SHOW = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [CW-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic           neg_q, neg_d, op_add_q, op_add_d;
  logic           disp_neg_q, disp_neg_d, done_q, done_d;
  logic [1:0]     op_val_q, op_val_d;

  logic is_digit, is_add, is_sub, is_eq, is_clr, is_op, clear_req;
  logic [W:0]   sum;
  logic         overflow;
  logic [W-1:0] diff;
  logic         a_ge_b;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_add   = key_valid && (key_code == 4'd10);
  assign is_sub   = key_valid && (key_code == 4'd11);
  assign is_eq    = key_valid && (key_code == 4'd12);
  assign is_clr   = key_valid && (key_code == 4'd13);
  assign is_op    = is_add || is_sub;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign overflow = sum > (W+1)'(MAX_VAL);
  assign a_ge_b   = a_q >= b_q;
  assign diff     = a_ge_b ? (a_q - b_q) : (b_q - a_q);

  // Entry is bounded by the digit counter, so acc*10+d always fits in W bits.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] acc, input logic [3:0] d);
    return W'({4'b0, acc} * (W+4)'(10) + (W+4)'(d));
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    neg_d     = neg_q;
    op_add_d  = op_add_q;
    op_val_d  = 2'b00;
    clear_req = 1'b0;

    case (state_q)
      S_A: begin
        if (is_clr) begin
          clear_req = 1'b1;
        end else if (is_digit && (cnt_a_q < CNT_FULL)) begin
          a_d     = shift_in(a_q, key_code);
          cnt_a_d = cnt_a_q + CW'(1);
        end else if (is_op) begin
          op_val_d = is_add ? 2'b01 : 2'b10;
          op_add_d = is_add;
          b_d      = '0;
          cnt_b_d  = '0;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (is_clr) begin
          clear_req = 1'b1;
        end else if (is_digit && (cnt_b_q < CNT_FULL)) begin
          b_d     = shift_in(b_q, key_code);
          cnt_b_d = cnt_b_q + CW'(1);
        end else if (is_op && (cnt_b_q == '0)) begin
          op_val_d = is_add ? 2'b01 : 2'b10;
          op_add_d = is_add;
        end else if (is_eq) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_add_q) begin
          if (overflow) begin
            state_d = S_ERR;
          end else begin
            res_d   = sum[W-1:0];
            neg_d   = 1'b0;
            state_d = S_SHOW;
          end
        end else begin
          res_d   = diff;
          neg_d   = !a_ge_b;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (is_clr) begin
          clear_req = 1'b1;
        end else if (is_digit) begin
          a_d     = W'(key_code);
          cnt_a_d = CW'(1);
          state_d = S_A;
        end else if (is_op && !neg_q) begin
          // Chaining: the result becomes a full-width operand A.
          a_d      = res_q;
          cnt_a_d  = CNT_FULL;
          op_val_d = is_add ? 2'b01 : 2'b10;
          op_add_d = is_add;
          b_d      = '0;
          cnt_b_d  = '0;
          state_d  = S_B;
        end
      end
      S_ERR: begin
        if (is_clr) clear_req = 1'b1;
      end
      default: state_d = S_A;
    endcase

    if (clear_req) begin
      state_d  = S_A;
      a_d      = '0;
      b_d      = '0;
      res_d    = '0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      neg_d    = 1'b0;
      op_add_d = 1'b1;
    end
  end

  always_comb begin
    disp_d     = disp_q;
    disp_neg_d = 1'b0;
    case (state_d)
      S_A:    disp_d = a_d;
      S_B:    disp_d = (cnt_b_d != '0) ? b_d : a_d;
      S_EXEC: disp_d = disp_q;
      S_SHOW: begin
        disp_d     = res_d;
        disp_neg_d = neg_d;
      end
      S_ERR:  disp_d = '0;
      default: disp_d = '0;
    endcase
    done_d = (state_q == S_EXEC) && (state_d == S_SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      neg_q      <= 1'b0;
      op_add_q   <= 1'b1;
      op_val_q   <= 2'b00;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      neg_q      <= neg_d;
      op_add_q   <= op_add_d;
      op_val_q   <= op_val_d;
      disp_q     <= disp_d;
      disp_neg_q <= disp_neg_d;
      done_q     <= done_d;
    end
  end

  assign op_val      = op_val_q;
  assign display_val = disp_q;
  assign display_neg = disp_neg_q;
  assign done        = done_q;
  assign busy        = (state_q == S_EXEC);
  assign err         = (state_q == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_calc_sequencer: directed keypad sequences with a queued scoreboard.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_calc_sequencer;
  localparam int NDIG = 4;
  localparam int W    = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic [1:0]   op_val;
  logic [W-1:0] display_val;
  logic         display_neg, done, busy, err;

  int total = 0;
  int bad   = 0;
  logic [1:0] q_op [$];
  logic [W:0] q_res [$];   // {neg, magnitude}

  calc_sequencer #(.NDIG(NDIG), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .op_val(op_val), .display_val(display_val), .display_neg(display_neg),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_num(input int n);
    if (n >= 1000) press(4'((n / 1000) % 10));
    if (n >= 100)  press(4'((n / 100) % 10));
    if (n >= 10)   press(4'((n / 10) % 10));
    press(4'(n % 10));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_disp"}, int'(display_val), 0);
    check({tag, "_neg"},  int'(display_neg), 0);
    check({tag, "_op"},   int'(op_val), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err"},  int'(err), 0);
  endtask

  // Monitor: every op_val pulse and done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_val != 2'b00) begin
        if (q_op.size() == 0) begin
          check("op_val_unexpected", int'(op_val), 0);
        end else begin
          logic [1:0] e_op;
          e_op = q_op.pop_front();
          check("op_val", int'(op_val), int'(e_op));
        end
      end
      if (done) begin
        if (q_res.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          logic [W:0] e_res;
          e_res = q_res.pop_front();
          check("result_val", int'(display_val), int'(e_res[W-1:0]));
          check("result_neg", int'(display_neg), int'(e_res[W]));
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    bad++;
    total++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    // 1: 12 + 7 = 19
    press_num(12);
    check("t1_a", int'(display_val), 12);
    q_op.push_back(2'b01);
    press(4'd10);
    check("t1_b_shows_a", int'(display_val), 12);
    press(4'd7);
    check("t1_b", int'(display_val), 7);
    q_res.push_back({1'b0, 14'd19});
    press(4'd12);
    check("t1_disp", int'(display_val), 19);

    // 2: 5 - 12 = -7, then '+' on a negative result is ignored
    press(4'd13);
    check("t2_clear", int'(display_val), 0);
    press(4'd5);
    q_op.push_back(2'b10);
    press(4'd11);
    press_num(12);
    q_res.push_back({1'b1, 14'd7});
    press(4'd12);
    press(4'd10);
    check("t2_disp", int'(display_val), 7);
    check("t2_neg", int'(display_neg), 1);

    // 3: 9999 + 1 overflows; digits ignored in error; clear recovers
    press(4'd13);
    press_num(9999);
    q_op.push_back(2'b01);
    press(4'd10);
    press(4'd1);
    press(4'd12);
    check("t3_err", int'(err), 1);
    check("t3_disp", int'(display_val), 0);
    press(4'd3);
    check("t3_err_hold", int'(err), 1);
    check("t3_disp_hold", int'(display_val), 0);
    press(4'd13);
    check("t3_clr_err", int'(err), 0);
    check("t3_clr_disp", int'(display_val), 0);

    // 4: fifth digit dropped; operator replaced before any B digit
    press_num(1234);
    press(4'd5);
    check("t4_a", int'(display_val), 1234);
    q_op.push_back(2'b01);
    press(4'd10);
    q_op.push_back(2'b10);
    press(4'd11);
    press(4'd6);
    q_res.push_back({1'b0, 14'd1228});
    press(4'd12);
    check("t4_disp", int'(display_val), 1228);

    // 5: chaining 3+4=7, +2=9, then a digit starts a fresh A
    press(4'd13);
    press(4'd3);
    q_op.push_back(2'b01);
    press(4'd10);
    press(4'd4);
    q_res.push_back({1'b0, 14'd7});
    press(4'd12);
    q_op.push_back(2'b01);
    press(4'd10);
    check("t5_chain_a", int'(display_val), 7);
    press(4'd2);
    q_res.push_back({1'b0, 14'd9});
    press(4'd12);
    check("t5_disp", int'(display_val), 9);
    press(4'd5);
    check("t5_fresh_a", int'(display_val), 5);

    // 6: a digit arriving during S_EXEC is dropped
    press(4'd13);
    press(4'd3);
    q_op.push_back(2'b01);
    press(4'd10);
    press(4'd4);
    q_res.push_back({1'b0, 14'd7});
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd12;
    @(negedge clk);
    check("t6_busy", int'(busy), 1);
    key_code  = 4'd1;
    @(negedge clk);
    key_valid = 1'b0;
    check("t6_busy_off", int'(busy), 0);
    @(negedge clk);
    check("t6_disp", int'(display_val), 7);

    // 6b: reset while in S_B with A=42
    press(4'd13);
    press_num(42);
    q_op.push_back(2'b01);
    press(4'd10);
    check("t6_a42", int'(display_val), 42);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("t6_rst");
    rst_n = 1'b1;
    press(4'd8);
    check("t6_after_rst", int'(display_val), 8);

    repeat (3) @(negedge clk);
    check("op_queue_empty", q_op.size(), 0);
    check("res_queue_empty", q_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
